mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset, listed first.
REQ-002 Clk  input  1  rising-edge clock, shared with DataMemory.
REQ-003 Rst_n  input  1  asynchronous active-low reset.
REQ-004 Req  input  1  request strobe; sampled only in IDLE.
REQ-005 Op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-006 Addr  input  32  byte address.
REQ-007 Wdata  input  32  store data, right-justified for SH/SB.
REQ-008 Busy  output  1  high in every state except IDLE.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 Rdata  output  32  extended load result; held until the next load completes.
REQ-011 Exc  output  1  misalignment flag, pulsed with Done; tied 0 when MISALIGN_TRAP_EN is undefined.
REQ-012 Mem_Addr  output  32  word index to DataMemory, equal to {2'b00, latched Addr[31:2]}.
REQ-013 Mem_Data_in  output  32  write word to DataMemory.
REQ-014 Mem_We  output  1  write enable to DataMemory.
REQ-015 Mem_Data_out  input  32  combinational read word from DataMemory.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE and DONE.
REQ-017 IDLE with Req=1: SHALL latch Op/Addr/Wdata at the edge, then go to READ (loads, SH, SB) or WRITE (SW).
REQ-018 IDLE with Req=0: SHALL stay in IDLE; Req in any other state SHALL be ignored.
REQ-019 READ SHALL last one cycle, capturing Mem_Data_out at its closing edge.
  - Loads: READ then DONE.
  - SH/SB: READ then WRITE.
REQ-020 WRITE SHALL last one cycle with Mem_We=1; Mem_We SHALL be 0 in all other states.
REQ-021 DONE SHALL last one cycle with Done=1, then return to IDLE.
REQ-022 Latency: load and SW 2 cycles from acceptance edge to Done; SH/SB 3 cycles.
REQ-023 Byte order SHALL be big-endian: byte offset 0 = bits 31:24, halfword offset 0 = bits 31:16.
REQ-024 Load extension:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: unmodified word.
REQ-025 SH/SB merge: SHALL replace only the addressed lane of the READ word with Wdata[15:0]/Wdata[7:0]; other lanes unchanged.
REQ-026 SW: Mem_Data_in SHALL equal the latched Wdata.
REQ-027 Mem_Data_in SHALL be 0 outside WRITE.
REQ-028 Mem_Addr SHALL hold the latched word index from acceptance until the next acceptance.
REQ-029 Address wrap: Addr=0xFFFFFFFC SHALL map to word index 0x3FFFFFFF with no overflow handling.
REQ-030 Rdata SHALL update only at a load's READ-to-DONE edge; stores and trapped accesses SHALL leave it unchanged.

Reset
REQ-031 Rst_n=0 SHALL immediately force:
  - state IDLE;
  - Busy, Done, Exc, Mem_We = 0;
  - Rdata, Mem_Addr, Mem_Data_in = 0.
REQ-032 Reset asserted during READ or WRITE SHALL abort the access; no write is issued after Rst_n deasserts.
REQ-033 The first request SHALL be accepted at the first rising edge with Rst_n=1 and Req=1.

Configuration
REQ-034 Macro MISALIGN_TRAP_EN defined:
  - Misaligned accesses trap: LW/SW with Addr[1:0]!=0; LH/LHU/SH with Addr[0]!=0.
  - A trapped access SHALL go IDLE to DONE directly, with Exc=1 during DONE, Mem_We never asserted, Rdata unchanged; latency 1 cycle.
REQ-035 Macro MISALIGN_TRAP_EN undefined:
  - Addr[0] SHALL be ignored for halfwords, and Addr[1:0] for words.
  - Exc SHALL be constant 0.

Verification
REQ-036 Bench SHALL cover these directed scenarios (memory model: word 0 = 0x11223344, word 1 = 0x8899AABB):
  - LW Addr=0x0 -> Done 2 cycles after acceptance; Rdata=0x11223344; Mem_We never 1.
  - LB Addr=0x4 -> Rdata=0xFFFFFF88; LBU Addr=0x4 -> 0x00000088; LH Addr=0x6 -> 0xFFFFAABB; LHU Addr=0x6 -> 0x0000AABB.
  - SB Addr=0x5, Wdata=0x000000CC -> exactly one Mem_We pulse with Mem_Addr=1, Mem_Data_in=0x88CCAABB; Done 3 cycles after acceptance.
  - SW Addr=0x2, Wdata=0xDEADBEEF -> with MISALIGN_TRAP_EN: Exc=1 with Done after 1 cycle, no Mem_We; without it: word 0 written 0xDEADBEEF, Exc=0.
  - Rst_n pulled low mid-WRITE of an SH -> Mem_We falls without waiting for a clock; Busy=0; Rdata=0; word unchanged after release.
  - Req held high continuously -> back-to-back LW requests accepted only in IDLE; Done pulses never overlap Busy-accept edges.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer between a core request port and a word-wide DataMemory
//
// Purpose: accepts one load/store request in IDLE, performs a READ and/or WRITE
// cycle against a combinational-read DataMemory, extends load data and merges
// sub-word stores (big-endian lanes), then pulses Done for one cycle.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses skip memory and raise Exc.
//
// Ports:
//   Clk, Rst_n         clock, asynchronous active-low reset
//   Req, Op, Addr,     request strobe, opcode, byte address, store data
//   Wdata
//   Busy, Done, Exc    status: not idle, completion pulse, misalignment flag
//   Rdata              extended load result, held until the next load completes
//   Mem_Addr           word index to DataMemory
//   Mem_Data_in,       write word and write enable to DataMemory
//   Mem_We
//   Mem_Data_out       combinational read word from DataMemory
module mem_access_unit (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Rdata,
  output logic        Exc,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Data_in,
  output logic        Mem_We,
  input  logic [31:0] Mem_Data_out
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        trap;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [31:0] wr_word;

`ifdef MISALIGN_TRAP_EN
  logic exc_q;

  // Decided on the incoming request so a trapped access never touches memory.
  always_comb begin
    trap = 1'b0;
    case (Op)
      OP_LW, OP_SW:         trap = |Addr[1:0];
      OP_LH, OP_LHU, OP_SH: trap = Addr[0];
      default:              trap = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                         exc_q <= 1'b0;
    else if (state_q == S_IDLE && Req)  exc_q <= trap;
  end

  assign Exc = exc_q && (state_q == S_DONE);
`else
  assign trap = 1'b0;
  assign Exc  = 1'b0;
`endif

  // Big-endian lane selection: offset 0 is the most significant lane.
  always_comb begin
    rd_half = addr_q[1] ? Mem_Data_out[15:0] : Mem_Data_out[31:16];
    case (addr_q[1:0])
      2'd0:    rd_byte = Mem_Data_out[31:24];
      2'd1:    rd_byte = Mem_Data_out[23:16];
      2'd2:    rd_byte = Mem_Data_out[15:8];
      default: rd_byte = Mem_Data_out[7:0];
    endcase
    case (op_q)
      OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_val = {16'h0000, rd_half};
      OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_val = {24'h000000, rd_byte};
      default: load_val = Mem_Data_out;
    endcase
  end

  // Sub-word store: overwrite only the addressed lane of the word read earlier.
  always_comb begin
    merged = word_q;
    if (op_q == OP_SH) begin
      if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
      else           merged[31:16] = wdata_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end
    wr_word = (op_q == OP_SW) ? wdata_q : merged;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          op_d    = Op;
          addr_d  = Addr;
          wdata_d = Wdata;
          if (trap)              state_d = S_DONE;
          else if (Op == OP_SW)  state_d = S_WRITE;
          else                   state_d = S_READ;
        end
      end
      S_READ: begin
        word_d = Mem_Data_out;
        if (op_q == OP_SH || op_q == OP_SB) begin
          state_d = S_WRITE;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LW;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  // Write strobe and data decode straight from state so reset drops them at once.
  assign Busy        = (state_q != S_IDLE);
  assign Done        = (state_q == S_DONE);
  assign Mem_We      = (state_q == S_WRITE);
  assign Mem_Data_in = (state_q == S_WRITE) ? wr_word : 32'h0;
  assign Mem_Addr    = {2'b00, addr_q[31:2]};
  assign Rdata       = rdata_q;

endmodule
